// File: rtl/maxpool1.sv
// 2x2 stride-2 max-pooling stage for a raster-ordered IMG_W x IMG_H signed feature map.
// One row of horizontal pair maxima is buffered, so no frame storage is needed.
module maxpool1 #(
    parameter int DATA_W = 22,
    parameter int IMG_W  = 24,
    parameter int IMG_H  = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     done_pool1
);

    localparam int COL_W = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int LB_D  = (IMG_W / 2 > 0) ? IMG_W / 2 : 1;
    localparam int LB_AW = (LB_D > 1) ? $clog2(LB_D) : 1;

    if ((IMG_W % 2) != 0 || IMG_W < 2) begin : g_bad_width
        $error("maxpool1: IMG_W must be even and at least 2");
    end
    if ((IMG_H % 2) != 0 || IMG_H < 2) begin : g_bad_height
        $error("maxpool1: IMG_H must be even and at least 2");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                     r_state;
    logic [COL_W-1:0]           r_col;
    logic [ROW_W-1:0]           r_row;
    logic signed [DATA_W-1:0]   r_pair;
    logic signed [DATA_W-1:0]   r_linebuf [LB_D];

    logic                       w_accept;
    logic                       w_col_odd;
    logic                       w_row_odd;
    logic                       w_col_last;
    logic                       w_row_last;
    logic [LB_AW-1:0]           w_lb_idx;
    logic signed [DATA_W-1:0]   w_lb_rd;
    logic signed [DATA_W-1:0]   w_pair_max;
    logic signed [DATA_W-1:0]   w_win_max;

    function automatic logic signed [DATA_W-1:0] smax(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    assign w_accept   = (r_state == S_RUN) && enable && in_valid;
    assign w_col_odd  = r_col[0];
    assign w_row_odd  = r_row[0];
    assign w_col_last = (r_col == COL_W'(IMG_W - 1));
    assign w_row_last = (r_row == ROW_W'(IMG_H - 1));
    assign w_lb_idx   = LB_AW'(r_col >> 1);
    assign w_lb_rd    = r_linebuf[w_lb_idx];
    assign w_pair_max = smax(r_pair, in_data);
    assign w_win_max  = smax(w_pair_max, w_lb_rd);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_col      <= '0;
            r_row      <= '0;
            r_pair     <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            done_pool1 <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_col      <= '0;
                    r_row      <= '0;
                    r_pair     <= '0;
                    out_valid  <= 1'b0;
                    out_data   <= '0;
                    done_pool1 <= 1'b0;
                    if (enable) r_state <= S_RUN;
                end
                S_RUN: begin
                    out_valid <= 1'b0;
                    if (!enable) begin
                        // Abort: partial frame is dropped, outputs return to idle values.
                        r_state  <= S_IDLE;
                        r_col    <= '0;
                        r_row    <= '0;
                        out_data <= '0;
                    end else if (in_valid) begin
                        if (!w_col_odd) begin
                            r_pair <= in_data;
                        end else if (w_row_odd) begin
                            out_data  <= w_win_max;
                            out_valid <= 1'b1;
                        end
                        if (w_col_last) begin
                            r_col <= '0;
                            if (w_row_last) begin
                                r_row      <= '0;
                                r_state    <= S_DONE;
                                done_pool1 <= 1'b1;
                            end else begin
                                r_row <= r_row + 1'b1;
                            end
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    out_valid  <= 1'b0;
                    done_pool1 <= 1'b1;
                    if (!enable) begin
                        r_state    <= S_IDLE;
                        done_pool1 <= 1'b0;
                        out_data   <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // NOTE: the line buffer has no reset; every entry is written on an even row before it is read.
    always_ff @(posedge clk) begin
        if (rst_n && w_accept && w_col_odd && !w_row_odd) begin
            r_linebuf[w_lb_idx] <= w_pair_max;
        end
    end

endmodule

// File: tb/tb_maxpool1.sv
// Self-checking bench for maxpool1: default 24x24, 4x4 and 2x2 instances, compared
// against window maxima computed directly from the stored input frame.
module tb_maxpool1;

    localparam int DW = 22;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic                 enable;
    logic                 in_valid;
    logic signed [DW-1:0] in_data;
    int                   sel;

    logic en_d, en_4, en_2;
    logic ov_d, ov_4, ov_2;
    logic dn_d, dn_4, dn_2;
    logic signed [DW-1:0] od_d, od_4, od_2;

    assign en_d = enable && (sel == 0);
    assign en_4 = enable && (sel == 1);
    assign en_2 = enable && (sel == 2);

    maxpool1 u_dut_d (
        .clk(clk), .rst_n(rst_n), .enable(en_d), .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov_d), .out_data(od_d), .done_pool1(dn_d)
    );
    maxpool1 #(.DATA_W(DW), .IMG_W(4), .IMG_H(4)) u_dut_4 (
        .clk(clk), .rst_n(rst_n), .enable(en_4), .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov_4), .out_data(od_4), .done_pool1(dn_4)
    );
    maxpool1 #(.DATA_W(DW), .IMG_W(2), .IMG_H(2)) u_dut_2 (
        .clk(clk), .rst_n(rst_n), .enable(en_2), .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov_2), .out_data(od_2), .done_pool1(dn_2)
    );

    logic                 ov, dn;
    logic signed [DW-1:0] od;
    assign ov = (sel == 0) ? ov_d : (sel == 1) ? ov_4 : ov_2;
    assign dn = (sel == 0) ? dn_d : (sel == 1) ? dn_4 : dn_2;
    assign od = (sel == 0) ? od_d : (sel == 1) ? od_4 : od_2;

    int checks = 0;
    int errors = 0;
    int w_cur, h_cur;
    int pulses;
    logic signed [DW-1:0] frame [576];

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic select(input int s);
        sel   = s;
        w_cur = (s == 0) ? 24 : (s == 1) ? 4 : 2;
        h_cur = w_cur;
    endtask

    // Reference: maximum of the 2x2 window whose bottom-right pixel is (r,c).
    function automatic logic signed [DW-1:0] win_max(input int r, input int c);
        logic signed [DW-1:0] m;
        m = frame[(r - 1) * w_cur + c - 1];
        for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++)
                if (frame[(r - 1 + dr) * w_cur + c - 1 + dc] > m)
                    m = frame[(r - 1 + dr) * w_cur + c - 1 + dc];
        return m;
    endfunction

    task automatic run_frame(input int n_beats, input int gap_pct);
        int r, c;
        enable   = 1'b1;
        in_valid = 1'b0;
        step();
        chk("run_entry_valid", ov, 0);
        chk("run_entry_done", dn, 0);
        pulses = 0;
        for (int b = 0; b < n_beats; b++) begin
            for (int g = 0; g < 8 && $urandom_range(99) < gap_pct; g++) begin
                in_valid = 1'b0;
                in_data  = DW'($urandom());
                step();
                chk("gap_valid", ov, 0);
            end
            in_valid = 1'b1;
            in_data  = frame[b];
            step();
            r = b / w_cur;
            c = b % w_cur;
            if ((r % 2 == 1) && (c % 2 == 1)) begin
                chk("pulse_valid", ov, 1);
                chk("pulse_data", od, win_max(r, c));
                pulses++;
            end else begin
                chk("quiet_valid", ov, 0);
            end
            chk("done_flag", dn, (b == w_cur * h_cur - 1) ? 1 : 0);
        end
        in_valid = 1'b0;
    endtask

    task automatic end_frame();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = DW'($urandom());
            step();
            chk("done_held", dn, 1);
            chk("done_no_pulse", ov, 0);
        end
        in_valid = 1'b0;
        enable   = 1'b0;
        step();
        chk("idle_done", dn, 0);
        chk("idle_valid", ov, 0);
        chk("idle_data", od, 0);
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < w_cur * h_cur; i++) frame[i] = DW'(i);
    endtask

    initial begin
        rst_n    = 1'b0;
        enable   = 1'b1;
        in_valid = 1'b1;
        in_data  = '0;
        select(0);

        // Reset held while enable and in_valid are active
        for (int i = 0; i < 2; i++) begin
            in_data = DW'($urandom());
            step();
            chk("reset_valid", ov, 0);
            chk("reset_data", od, 0);
            chk("reset_done", dn, 0);
        end
        rst_n    = 1'b1;
        enable   = 1'b0;
        in_valid = 1'b0;
        step();

        // 4x4 ramp, continuous beats
        select(1);
        fill_ramp();
        run_frame(16, 0);
        chk("small_pulses", pulses, 4);
        chk("small_last_data", od, 15);
        end_frame();

        // 24x24 ramp, continuous beats
        select(0);
        fill_ramp();
        run_frame(576, 0);
        chk("ramp_pulses", pulses, 144);
        chk("ramp_last_data", od, 23 * 24 + 23);
        end_frame();

        // Same ramp with random in_valid gaps
        run_frame(576, 50);
        chk("gap_pulses", pulses, 144);
        end_frame();

        // Random signed data with gaps
        for (int i = 0; i < 576; i++) frame[i] = DW'($urandom());
        run_frame(576, 30);
        chk("rand_pulses", pulses, 144);
        end_frame();

        // 2x2 signed windows and ties
        select(2);
        frame[0] = -5; frame[1] = -3; frame[2] = -8; frame[3] = -1;
        run_frame(4, 0);
        chk("neg_result", od, -1);
        end_frame();
        for (int i = 0; i < 4; i++) frame[i] = 7;
        run_frame(4, 0);
        chk("tie_result", od, 7);
        end_frame();

        // Abort after 30 beats, then a fresh full frame
        select(0);
        fill_ramp();
        run_frame(30, 0);
        enable   = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = DW'($urandom());
            step();
            chk("abort_valid", ov, 0);
            chk("abort_done", dn, 0);
            chk("abort_data", od, 0);
        end
        in_valid = 1'b0;
        run_frame(576, 0);
        chk("restart_pulses", pulses, 144);
        end_frame();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
